beam_delay_ctrl: RTL and testbench

Parametrised, double-buffered receive-focus delay controller for the beamforming path. It accepts focal points over a valid/ready handshake and computes one delay per channel by sequencing an external delay calculator. Results go to a shadow bank, which swaps into the active bank on a frame boundary. Each channel's input sample stream then passes through a circular delay line addressed by the active delay, so delays for the next focal point are computed while the current ones stay in use.

---
 rtl/beam_delay_pkg.sv | 25 ++
 rtl/beam_delay_line.sv | 50 +++++
 rtl/beam_delay_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_beam_delay_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beam_delay_pkg.sv
// rtl/beam_delay_pkg.sv - shared types, default parameters and helpers for beam_delay_ctrl
package beam_delay_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STORE,
        ST_NEXT,
        ST_PEND_SWAP
    } state_t;

    localparam int DEF_NUM_CHANNELS = 16;
    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_DELAY_WIDTH  = 9;
    localparam int DEF_MAX_DELAY    = 256;
    localparam int DEF_SWAP_ON_SYNC = 1;
    localparam int COORD_WIDTH      = 16;

    // Low bit index of channel ch inside a flat per-channel bus
    function automatic int slice_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/beam_delay_line.sv
// rtl/beam_delay_line.sv - one channel circular delay RAM with write-first read path
module beam_delay_line
    import beam_delay_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int MAX_DELAY   = DEF_MAX_DELAY
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_valid,
    input  logic [$clog2(MAX_DELAY)-1:0] wr_ptr,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [DELAY_WIDTH-1:0]       delay,
    input  logic [DELAY_WIDTH:0]         fill_inc,
    output logic [DATA_WIDTH-1:0]        dout,
    output logic                         valid
);

    localparam int AW = $clog2(MAX_DELAY);

    logic [DATA_WIDTH-1:0]  mem [MAX_DELAY];
    logic [DELAY_WIDTH-1:0] rd_diff;
    logic [AW-1:0]          rd_addr;

    // Subtract at full delay width, then keep the RAM address bits (modulo depth)
    assign rd_diff = DELAY_WIDTH'(wr_ptr) - delay;
    assign rd_addr = rd_diff[AW-1:0];

    // Sample storage, written at the shared write pointer
    always_ff @(posedge clk) begin
        if (s_valid) begin
            mem[wr_ptr] <= din;
        end
    end

    // Registered read; a read of the slot being written returns the new sample
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dout  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= s_valid && (fill_inc > {1'b0, delay});
            if (s_valid) begin
                dout <= (rd_addr == wr_ptr) ? din : mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/beam_delay_ctrl.sv
// rtl/beam_delay_ctrl.sv - double-buffered receive-focus delay controller (option: BEAM_DELAY_CLAMP_EN)
module beam_delay_ctrl
    import beam_delay_pkg::*;
#(
    parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DELAY_WIDTH  = DEF_DELAY_WIDTH,
    parameter int MAX_DELAY    = DEF_MAX_DELAY,
    parameter int SWAP_ON_SYNC = DEF_SWAP_ON_SYNC
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               fp_valid,
    output logic                               fp_ready,
    input  logic [COORD_WIDTH-1:0]             x_f,
    input  logic [COORD_WIDTH-1:0]             z_f,
    output logic                               calc_req,
    output logic [$clog2(NUM_CHANNELS)-1:0]    calc_ch,
    output logic [COORD_WIDTH-1:0]             calc_xf,
    output logic [COORD_WIDTH-1:0]             calc_zf,
    input  logic                               calc_done,
    input  logic [DELAY_WIDTH-1:0]             calc_delay,
    input  logic                               frame_sync,
    input  logic                               s_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] din_flat,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] delayed_flat,
    output logic [NUM_CHANNELS-1:0]            valid_b,
    output logic                               swap_done,
    output logic                               sat_flag
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int AW = $clog2(MAX_DELAY);
    localparam logic [DELAY_WIDTH-1:0] DELAY_MAX = DELAY_WIDTH'(MAX_DELAY - 1);
    localparam logic [DELAY_WIDTH:0]   FILL_FULL = (DELAY_WIDTH + 1)'(MAX_DELAY);
    localparam logic [CW-1:0]          LAST_CH   = CW'(NUM_CHANNELS - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          idx;
    logic [DELAY_WIDTH-1:0] calc_res;
    logic [DELAY_WIDTH-1:0] store_val;
    logic [DELAY_WIDTH-1:0] shadow [NUM_CHANNELS];
    logic [DELAY_WIDTH-1:0] active [NUM_CHANNELS];
    logic [AW-1:0]          wr_ptr;
    logic [DELAY_WIDTH:0]   fill;
    logic [DELAY_WIDTH:0]   fill_inc;
    logic                   do_swap;

    assign calc_ch = idx;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/strobe decode
    always_comb begin
        state_nxt = state;
        fp_ready  = 1'b0;
        calc_req  = 1'b0;
        do_swap   = 1'b0;
        case (state)
            ST_IDLE: begin
                fp_ready = 1'b1;
                if (fp_valid) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                calc_req  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (calc_done) state_nxt = ST_STORE;
            end
            ST_STORE: begin
                state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                state_nxt = (idx == LAST_CH) ? ST_PEND_SWAP : ST_REQ;
            end
            ST_PEND_SWAP: begin
                if (SWAP_ON_SYNC == 0 || frame_sync) begin
                    do_swap   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Focal point latch, channel sequencing and calculator result capture
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx      <= '0;
            calc_xf  <= '0;
            calc_zf  <= '0;
            calc_res <= '0;
        end else begin
            if (state == ST_IDLE && fp_valid) begin
                calc_xf <= x_f;
                calc_zf <= z_f;
                idx     <= '0;
            end
            if (state == ST_WAIT && calc_done) begin
                calc_res <= calc_delay;
            end
            if (state == ST_NEXT && idx != LAST_CH) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef BEAM_DELAY_CLAMP_EN
    logic clamp_hit;

    assign clamp_hit = calc_res > DELAY_MAX;
    assign store_val = clamp_hit ? DELAY_MAX : calc_res;

    // Sticky record that some stored delay had to be clamped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sat_flag <= 1'b0;
        end else if (state == ST_STORE && clamp_hit) begin
            sat_flag <= 1'b1;
        end
    end
`else
    // Out-of-range delays wrap modulo the delay-line depth
    assign store_val = calc_res & DELAY_MAX;
    assign sat_flag  = 1'b0;
`endif

    // Shadow bank fill and whole-bank swap into the active set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            swap_done <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            swap_done <= do_swap;
            if (state == ST_STORE) begin
                shadow[idx] <= store_val;
            end
            if (do_swap) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    assign fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;

    // Shared write pointer and saturating fill count, independent of the FSM
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (s_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            fill   <= fill_inc;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        beam_delay_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DELAY_WIDTH(DELAY_WIDTH),
            .MAX_DELAY  (MAX_DELAY)
        ) u_line (
            .clk     (clk),
            .reset_n (reset_n),
            .s_valid (s_valid),
            .wr_ptr  (wr_ptr),
            .din     (din_flat[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
            .delay   (active[i]),
            .fill_inc(fill_inc),
            .dout    (delayed_flat[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
            .valid   (valid_b[i])
        );
    end

endmodule

// File: tb/tb_beam_delay_ctrl.sv
// tb/tb_beam_delay_ctrl.sv - scoreboard testbench for beam_delay_ctrl (expectations follow BEAM_DELAY_CLAMP_EN)
module tb_beam_delay_ctrl;
    import beam_delay_pkg::*;

    localparam int NCH = 16;
    localparam int DW  = 16;
    localparam int LW  = 9;
    localparam int CHW = 4;

`ifdef BEAM_DELAY_CLAMP_EN
    localparam int EXP_CLAMP = 255;
    localparam int EXP_SAT   = 1;
`else
    localparam int EXP_CLAMP = 44;
    localparam int EXP_SAT   = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, frame_sync, s_valid;
    logic [15:0]       x_f, z_f;
    logic [NCH*DW-1:0] din_flat;

    logic              fp_valid, fp_ready, calc_req, calc_done, swap_done, sat_flag;
    logic [CHW-1:0]    calc_ch;
    logic [15:0]       calc_xf, calc_zf;
    logic [LW-1:0]     calc_delay;
    logic [NCH*DW-1:0] delayed_flat;
    logic [NCH-1:0]    valid_b;

    logic              fp_valid_s, fp_ready_s, calc_req_s, calc_done_s, swap_done_s, sat_flag_s;
    logic [CHW-1:0]    calc_ch_s;
    logic [15:0]       calc_xf_s, calc_zf_s;
    logic [LW-1:0]     calc_delay_s;
    logic [NCH*DW-1:0] delayed_flat_s;
    logic [NCH-1:0]    valid_b_s;

    beam_delay_ctrl #(.SWAP_ON_SYNC(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .fp_valid(fp_valid), .fp_ready(fp_ready),
        .x_f(x_f), .z_f(z_f), .calc_req(calc_req), .calc_ch(calc_ch),
        .calc_xf(calc_xf), .calc_zf(calc_zf), .calc_done(calc_done), .calc_delay(calc_delay),
        .frame_sync(frame_sync), .s_valid(s_valid), .din_flat(din_flat),
        .delayed_flat(delayed_flat), .valid_b(valid_b), .swap_done(swap_done), .sat_flag(sat_flag)
    );

    beam_delay_ctrl #(.SWAP_ON_SYNC(1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .fp_valid(fp_valid_s), .fp_ready(fp_ready_s),
        .x_f(x_f), .z_f(z_f), .calc_req(calc_req_s), .calc_ch(calc_ch_s),
        .calc_xf(calc_xf_s), .calc_zf(calc_zf_s), .calc_done(calc_done_s), .calc_delay(calc_delay_s),
        .frame_sync(frame_sync), .s_valid(1'b0), .din_flat(din_flat),
        .delayed_flat(delayed_flat_s), .valid_b(valid_b_s), .swap_done(swap_done_s), .sat_flag(sat_flag_s)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tab [NCH];
    int mdl_act [NCH];
    int g = 0;
    int swap_cnt = 0;
    int swap_cnt_s = 0;
    int pend = 0;
    int pend_s = 0;
    logic [CHW-1:0] lat_ch, lat_ch_s;
    logic [15:0]    exp_x;
    int exp_ch_q[$];

    typedef struct {
        logic [NCH-1:0]    v;
        logic [NCH*DW-1:0] d;
    } beat_t;
    beat_t beat_q[$];
    logic  sv_d = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Calculator models: result = tab[ch] four cycles after each request
    always @(negedge clk) begin
        calc_done = 1'b0;
        if (!reset_n) pend = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                calc_done  = 1'b1;
                calc_delay = LW'(tab[lat_ch]);
            end
        end
        if (reset_n && calc_req) begin
            pend   = 4;
            lat_ch = calc_ch;
        end
    end

    always @(negedge clk) begin
        calc_done_s = 1'b0;
        if (!reset_n) pend_s = 0;
        if (pend_s > 0) begin
            pend_s--;
            if (pend_s == 0) begin
                calc_done_s  = 1'b1;
                calc_delay_s = LW'(tab[lat_ch_s]);
            end
        end
        if (reset_n && calc_req_s) begin
            pend_s   = 4;
            lat_ch_s = calc_ch_s;
        end
    end

    // Request monitor: every calc_req must match the next expected channel
    always @(negedge clk) begin
        if (reset_n && calc_req) begin
            if (exp_ch_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL calc_unexpected: got ch %0d expected no request", calc_ch);
            end else begin
                check("calc_ch", calc_ch, exp_ch_q.pop_front());
                check("calc_xf", calc_xf, exp_x);
            end
        end
    end

    always @(negedge clk) begin
        if (swap_done)   swap_cnt++;
        if (swap_done_s) swap_cnt_s++;
    end

    always @(posedge clk) sv_d <= s_valid;

    // Sample monitor: one output beat per input beat, data checked on valid lanes
    always @(negedge clk) begin
        beat_t             e;
        logic [NCH*DW-1:0] m;
        if (reset_n && sv_d) begin
            if (beat_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL beat_unexpected: got valid_b %0h expected no beat", valid_b);
            end else begin
                e = beat_q.pop_front();
                for (int i = 0; i < NCH; i++) m[i*DW +: DW] = {DW{e.v[i]}};
                n_tests++;
                if (valid_b !== e.v || ((delayed_flat ^ e.d) & m) != '0) begin
                    n_fail++;
                    $display("FAIL beat_data: got valid %0h data %0h expected valid %0h data %0h",
                             valid_b, delayed_flat & m, e.v, e.d & m);
                end
            end
        end
    end

    task automatic beats(input int n);
        beat_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                din_flat[i*DW +: DW] = DW'((i << 12) | (g & 'hfff));
                e.v[i]               = (g + 1 > mdl_act[i]);
                e.d[i*DW +: DW]      = DW'((i << 12) | ((g - mdl_act[i]) & 'hfff));
            end
            beat_q.push_back(e);
            g++;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic run_fp(input logic [15:0] x, input logic [15:0] z);
        int t = 0;
        @(posedge clk); #1;
        fp_valid = 1'b1;
        x_f      = x;
        z_f      = z;
        exp_x    = x;
        for (int i = 0; i < NCH; i++) exp_ch_q.push_back(i);
        @(negedge clk);
        while (!fp_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        fp_valid = 1'b0;
    endtask

    task automatic wait_swap(input int prev);
        int t = 0;
        while (swap_cnt == prev && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (swap_cnt == prev) begin
            n_tests++;
            n_fail++;
            $display("FAIL swap_timeout: got no swap_done in %0d cycles expected one", t);
        end
        repeat (4) @(negedge clk);
        check("swap_once", swap_cnt, prev + 1);
    endtask

    initial begin
        int prev;
        int t;
        reset_n    = 1'b0;
        frame_sync = 1'b0;
        s_valid    = 1'b0;
        fp_valid   = 1'b0;
        fp_valid_s = 1'b0;
        x_f        = '0;
        z_f        = '0;
        din_flat   = '0;
        calc_done  = 1'b0;
        calc_delay = '0;
        calc_done_s  = 1'b0;
        calc_delay_s = '0;
        for (int i = 0; i < NCH; i++) mdl_act[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_fp_ready", fp_ready, 1);
        check("rst_calc_req", calc_req, 0);
        check("rst_swap_done", swap_done, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_valid_b", valid_b, 0);
        check("rst_delayed", |delayed_flat, 0);
        check("rst_fp_ready_s", fp_ready_s, 1);

        // Delays 2i+1, immediate swap
        for (int i = 0; i < NCH; i++) tab[i] = 2 * i + 1;
        prev = swap_cnt;
        run_fp(16'h0123, 16'h0456);
        wait_swap(prev);
        check("active5", u_dut.active[5], 11);
        check("active15", u_dut.active[15], 31);
        check("calc_zf", calc_zf, 16'h0456);
        check("calc_all_issued", exp_ch_q.size(), 0);

        // All delays 3, then ramp from an empty delay line
        for (int i = 0; i < NCH; i++) tab[i] = 3;
        prev = swap_cnt;
        run_fp(16'h0200, 16'h0300);
        wait_swap(prev);
        for (int i = 0; i < NCH; i++) mdl_act[i] = 3;
        beats(20);

        // Out-of-range delay on channel 0, samples keep flowing during compute
        for (int i = 0; i < NCH; i++) tab[i] = 2 * i + 1;
        tab[0] = 300;
        prev = swap_cnt;
        fork
            run_fp(16'h0777, 16'h0888);
            beats(40);
        join
        wait_swap(prev);
        check("clamp_active0", u_dut.active[0], EXP_CLAMP);
        check("clamp_sat", sat_flag, EXP_SAT);
        check("clamp_active3", u_dut.active[3], 7);

        // Delay 255 across write-pointer wrap
        for (int i = 0; i < NCH; i++) tab[i] = 255;
        prev = swap_cnt;
        run_fp(16'h0999, 16'h0aaa);
        wait_swap(prev);
        for (int i = 0; i < NCH; i++) mdl_act[i] = 255;
        beats(600);

        // Frame-synchronised swap
        for (int i = 0; i < NCH; i++) tab[i] = 2 * i + 1;
        prev = swap_cnt_s;
        @(posedge clk); #1;
        fp_valid_s = 1'b1;
        @(posedge clk); #1;
        fp_valid_s = 1'b0;
        repeat (20) @(posedge clk);
        #1 frame_sync = 1'b1;
        @(posedge clk); #1;
        frame_sync = 1'b0;
        @(negedge clk);
        check("sync_early_ready", fp_ready_s, 0);
        t = 0;
        while (u_dut_s.state != ST_PEND_SWAP && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("sync_reached_pend", t < 1000, 1);
        repeat (40) @(posedge clk);
        check("sync_no_early_swap", swap_cnt_s, prev);
        check("sync_ready_held", fp_ready_s, 0);
        #1 frame_sync = 1'b1;
        @(negedge clk);
        check("sync_not_yet", swap_done_s, 0);
        @(posedge clk); #1;
        frame_sync = 1'b0;
        @(negedge clk);
        check("sync_swap_done", swap_done_s, 1);
        check("sync_ready_back", fp_ready_s, 1);
        check("sync_active5", u_dut_s.active[5], 11);
        @(negedge clk);
        check("sync_pulse_one", swap_done_s, 0);

        // Reset during WAIT of channel 7
        prev = swap_cnt;
        run_fp(16'h0bbb, 16'h0ccc);
        t = 0;
        @(negedge clk);
        while (!(calc_req && calc_ch == 4'd7) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("rst7_seen_req", t < 500, 1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        exp_ch_q.delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst7_fp_ready", fp_ready, 1);
        check("rst7_calc_req", calc_req, 0);
        check("rst7_valid_b", valid_b, 0);
        check("rst7_delayed", |delayed_flat, 0);
        check("rst7_sat", sat_flag, 0);
        check("rst7_active5", u_dut.active[5], 0);
        repeat (300) @(negedge clk);
        check("rst7_no_swap", swap_cnt, prev);
        check("rst7_idle", fp_ready, 1);
        check("beats_drained", beat_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
